fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the accumulator core, replacing the bare PC register and the free-running cycle counter.
- Owns the program counter and drives the combinational InstROM address.
- Holds one registered instruction slot and presents it to Ctrl through a valid/ready handshake.
- Applies relative or absolute branch redirects, handles halt/done, and keeps saturating cycle and retired-instruction counters.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/sat_counter.sv | 26 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the accumulator core front end.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic BR_REL = 1'b0;
  localparam logic BR_ABS = 1'b1;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int TGT_W   = 8;
  localparam int CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; clr has priority over en.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         start,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, one registered instruction slot
// with a valid/ready handshake, branch redirect, halt and activity counters.
//
// state  | meaning
// IDLE   | out of reset, waiting for go
// RUN    | fetching and presenting instructions
// HALTED | halt consumed, done=1, waiting for go to restart
module fetch_unit #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int TGT_W   = cpu_pkg::TGT_W,
  parameter int CNT_W   = cpu_pkg::CNT_W
) (
  input  logic               CLK,
  input  logic               start,
  input  logic               go,
  input  logic [PC_W-1:0]    start_addr,
  output logic [PC_W-1:0]    inst_addr,
  input  logic [INSTR_W-1:0] inst_in,
  output logic [INSTR_W-1:0] inst_out,
  output logic [PC_W-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               branch_taken,
  input  logic               branch_abs,
  input  logic [TGT_W-1:0]   branch_target,
  input  logic               halt,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_ct,
  output logic [CNT_W-1:0]   instr_ct
);

  import cpu_pkg::*;

  fetch_state_t        state_q;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  inst_q;
  logic [PC_W-1:0]     inst_pc_q;
  logic                valid_q;
  logic                done_q;

  logic                consume;
  logic                restart;
  logic [PC_W-1:0]     br_pc_d;

  assign consume = valid_q && inst_ready && (state_q == RUN);
  assign restart = go && (state_q != RUN);

  // Relative offsets are taken from the consumed instruction's own address.
  assign br_pc_d = (branch_abs == BR_ABS) ? PC_W'(branch_target)
                                          : inst_pc_q + PC_W'($signed(branch_target));

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (go) begin
            state_q <= RUN;
            pc_q    <= start_addr;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (consume && halt) begin
            state_q <= HALTED;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (consume && branch_taken) begin
            valid_q <= 1'b0;
            pc_q    <= br_pc_d;
          end else if (!valid_q || consume) begin
            inst_q    <= inst_in;
            inst_pc_q <= pc_q;
            valid_q   <= 1'b1;
            pc_q      <= pc_q + PC_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_ct (
    .CLK   (CLK),
    .start (start),
    .clr   (restart),
    .en    (state_q == RUN),
    .q     (cycle_ct)
  );

  sat_counter #(.W(CNT_W)) u_instr_ct (
    .CLK   (CLK),
    .start (start),
    .clr   (restart),
    .en    (consume),
    .q     (instr_ct)
  );

  assign inst_addr  = pc_q;
  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected consumed addresses are queued by
// the stimulus and popped by a negedge monitor on every handshake.
module tb_fetch_unit;

  logic        CLK;
  logic        start;
  logic        go;
  logic [9:0]  start_addr;
  logic [9:0]  inst_addr;
  logic [8:0]  inst_in;
  logic [8:0]  inst_out;
  logic [9:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        branch_taken;
  logic        branch_abs;
  logic [7:0]  branch_target;
  logic        halt;
  logic        done;
  logic [15:0] cycle_ct;
  logic [15:0] instr_ct;

  logic [9:0]  s_inst_addr;
  logic [8:0]  s_inst_out;
  logic [9:0]  s_inst_pc;
  logic        s_inst_valid;
  logic        s_done;
  logic [3:0]  s_cycle_ct;
  logic [3:0]  s_instr_ct;

  logic [8:0]  rom [0:1023];
  logic [9:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;

  assign inst_in = rom[inst_addr];

  fetch_unit u_dut (
    .CLK(CLK), .start(start), .go(go), .start_addr(start_addr),
    .inst_addr(inst_addr), .inst_in(inst_in), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .branch_taken(branch_taken), .branch_abs(branch_abs),
    .branch_target(branch_target), .halt(halt), .done(done),
    .cycle_ct(cycle_ct), .instr_ct(instr_ct)
  );

  fetch_unit #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .start(start), .go(go), .start_addr(start_addr),
    .inst_addr(s_inst_addr), .inst_in(inst_in), .inst_out(s_inst_out),
    .inst_pc(s_inst_pc), .inst_valid(s_inst_valid), .inst_ready(inst_ready),
    .branch_taken(branch_taken), .branch_abs(branch_abs),
    .branch_target(branch_target), .halt(halt), .done(s_done),
    .cycle_ct(s_cycle_ct), .instr_ct(s_instr_ct)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_inst_addr"}, inst_addr, 0);
    chk({tag, "_inst_out"}, inst_out, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cycle_ct"}, cycle_ct, 0);
    chk({tag, "_instr_ct"}, instr_ct, 0);
    chk({tag, "_small_cycle_ct"}, s_cycle_ct, 0);
  endtask

  // Monitor: every handshake must match the next queued address and its ROM word.
  always @(negedge CLK) begin
    if (!start && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_consume: got inst_pc %0h expected no handshake", inst_pc);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("consume_pc", inst_pc, e);
        chk("consume_instr", inst_out, rom[e]);
      end
    end
  end

  initial begin
    start = 1'b0; go = 1'b0; start_addr = '0; inst_ready = 1'b0;
    branch_taken = 1'b0; branch_abs = 1'b0; branch_target = '0; halt = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 37 + 11) % 512);
    rom[5] = 9'h101; rom[6] = 9'h102; rom[7] = 9'h103;

    #1 start = 1'b1;
    #1 chk_reset("por");
    step(); step();
    start = 1'b0;
    step();
    chk("idle_cycle_ct", cycle_ct, 0);
    chk("idle_inst_addr", inst_addr, 0);

    // Straight-line fetch 5,6,7
    start_addr = 10'h005; go = 1'b1; inst_ready = 1'b1;
    exp_q.push_back(10'h005); exp_q.push_back(10'h006); exp_q.push_back(10'h007);
    step();
    go = 1'b0;
    chk("go_valid_low", inst_valid, 0);
    chk("go_inst_addr", inst_addr, 10'h005);
    step();
    chk("first_fetch_pc", inst_pc, 10'h005);
    step(); step(); step();
    inst_ready = 1'b0;
    chk("seq_instr_ct", instr_ct, 3);
    chk("seq_cycle_ct", cycle_ct, 4);
    chk("seq_next_pc", inst_pc, 10'h008);

    // Absolute branch to 0x10, then relative -2 to 0x0E
    branch_taken = 1'b1; branch_abs = 1'b1; branch_target = 8'h10; inst_ready = 1'b1;
    exp_q.push_back(10'h008);
    step();
    branch_taken = 1'b0;
    chk("bubble_abs", inst_valid, 0);
    exp_q.push_back(10'h010);
    step();
    branch_taken = 1'b1; branch_abs = 1'b0; branch_target = 8'hFE;
    step();
    branch_taken = 1'b0;
    chk("bubble_rel", inst_valid, 0);
    chk("rel_target_addr", inst_addr, 10'h00E);
    exp_q.push_back(10'h00E);
    step();

    // Branch while stalled must not redirect
    inst_ready = 1'b0; branch_taken = 1'b1; branch_abs = 1'b1; branch_target = 8'h3C;
    step();
    chk("stall_branch_pc", inst_pc, 10'h00E);
    chk("stall_branch_valid", inst_valid, 1);
    chk("stall_branch_addr", inst_addr, 10'h00F);
    inst_ready = 1'b1;
    step();
    branch_taken = 1'b0;
    chk("bubble_abs3c", inst_valid, 0);
    exp_q.push_back(10'h03C);
    step();
    chk("abs3c_pc", inst_pc, 10'h03C);

    // Go to 0x20 and stall 4 cycles (go in RUN is ignored)
    branch_taken = 1'b1; branch_abs = 1'b1; branch_target = 8'h20;
    step();
    branch_taken = 1'b0;
    exp_q.push_back(10'h020);
    step();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin go = 1'b1; start_addr = 10'h077; end
      step();
      go = 1'b0;
      chk("stall_pc", inst_pc, 10'h020);
      chk("stall_out", inst_out, rom[10'h020]);
      chk("stall_addr", inst_addr, 10'h021);
    end
    chk("stall_cycle_ct", cycle_ct, 17);
    chk("stall_instr_ct", instr_ct, 7);

    // Halt wins over branch
    inst_ready = 1'b1; halt = 1'b1; branch_taken = 1'b1; branch_abs = 1'b1; branch_target = 8'h55;
    step();
    halt = 1'b0; branch_taken = 1'b0;
    chk("halt_done", done, 1);
    chk("halt_valid", inst_valid, 0);
    chk("halt_addr", inst_addr, 10'h021);
    chk("halt_cycle_ct", cycle_ct, 18);
    chk("halt_instr_ct", instr_ct, 8);
    chk("sat_cycle_ct", s_cycle_ct, 15);
    chk("small_instr_ct", s_instr_ct, 8);
    step(); step(); step();
    chk("frozen_done", done, 1);
    chk("frozen_cycle_ct", cycle_ct, 18);
    chk("frozen_instr_ct", instr_ct, 8);
    chk("frozen_addr", inst_addr, 10'h021);

    // Restart from HALTED at 0
    go = 1'b1; start_addr = 10'h000;
    step();
    go = 1'b0;
    chk("restart_done", done, 0);
    chk("restart_cycle_ct", cycle_ct, 0);
    chk("restart_instr_ct", instr_ct, 0);
    chk("restart_addr", inst_addr, 0);
    chk("restart_small_cycle", s_cycle_ct, 0);
    exp_q.push_back(10'h000); exp_q.push_back(10'h001);
    step();
    chk("restart_pc", inst_pc, 0);
    step(); step();
    inst_ready = 1'b0;
    chk("restart_instr_ct2", instr_ct, 2);
    chk("restart_cycle_ct2", cycle_ct, 3);

    // Halt at 2, restart near the top of the address space to check wrap
    exp_q.push_back(10'h002);
    inst_ready = 1'b1; halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt2_done", done, 1);
    go = 1'b1; start_addr = 10'h3FE;
    step();
    go = 1'b0;
    exp_q.push_back(10'h3FE); exp_q.push_back(10'h3FF); exp_q.push_back(10'h000);
    step(); step(); step(); step();
    inst_ready = 1'b0;
    chk("wrap_pc", inst_pc, 10'h001);
    chk("wrap_addr", inst_addr, 10'h002);

    // Asynchronous reset in the middle of a stall
    #2 start = 1'b1;
    #1 chk_reset("mid_rst");
    chk("queue_empty", exp_q.size(), 0);
    step();
    start = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
